// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder (valid/ready request/response, aligned+extended loads); optional DMEM_RESP_ERR_EN flags misaligned/reserved accesses
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic                  r_we, r_sign, r_err;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic                  w_accept, w_access, w_we, w_sign, w_err, w_unused;
  logic [1:0]            w_size, w_off;
  logic [3:0]            w_be;
  logic [AW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_addr, w_wdata, w_wsh, w_word, w_rsh, w_load;
  assign w_accept = r_state == IDLE && req_valid;
  // with LATENCY==1 the access happens on the accept edge, so it must use the live request
  assign w_access = (w_accept && LATENCY == 1) || (r_state == WAIT && r_cnt == CW'(1));
  assign w_we    = r_state == IDLE ? req_we    : r_we;
  assign w_addr  = r_state == IDLE ? req_addr  : r_addr;
  assign w_wdata = r_state == IDLE ? req_wdata : r_wdata;
  assign w_size  = r_state == IDLE ? req_size  : r_size;
  assign w_sign  = r_state == IDLE ? req_sign  : r_sign;
  assign w_idx   = w_addr[2 +: AW];
`ifdef DMEM_RESP_ERR_EN
  assign w_err = (w_size == 2'b01 && w_addr[0]) || (w_size == 2'b10 && w_addr[1:0] != 2'b00) || w_size == 2'b11;
`else
  assign w_err = 1'b0;
`endif
  assign w_off  = w_size == 2'b00 ? w_addr[1:0] : w_size == 2'b01 ? {w_addr[1], 1'b0} : 2'b00;
  assign w_be   = w_size == 2'b00 ? 4'b0001 << w_off : w_size == 2'b01 ? 4'b0011 << w_off : 4'b1111;
  assign w_wsh  = w_wdata << {w_off, 3'b000};
  assign w_word = r_mem[w_idx];
  assign w_rsh  = w_word >> {w_off, 3'b000};
  assign w_load = w_size == 2'b00 ? {{(DATA_WIDTH-8){w_sign & w_rsh[7]}}, w_rsh[7:0]} :
                  w_size == 2'b01 ? {{(DATA_WIDTH-16){w_sign & w_rsh[15]}}, w_rsh[15:0]} : w_word;
  assign w_unused = ^{w_addr[DATA_WIDTH-1:AW+2], w_rsh[DATA_WIDTH-1:16]};
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  // storage write on the access edge; a reset on that edge drops the store
  always_ff @(posedge clk)
    if (w_access && !rst && w_we && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
  // next state: WAIT counts down to the access, then one more edge registers the result into RESP
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    if (w_accept) begin
      w_next = WAIT;
      w_cnt_next = CW'(LATENCY - 1);
    end else if (r_state == WAIT) begin
      w_next = r_cnt == '0 ? RESP : WAIT;
      w_cnt_next = r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
    end else if (r_state == RESP && rsp_ready)
      w_next = IDLE;
  end
  // state, request latch and response registers
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_sign  <= req_sign;
      end
      if (w_access) begin
        r_rdata <= w_we || w_err ? '0 : w_load;
        r_err   <= w_err;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024)
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int          checks = 0, failures = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic sign, input logic [31:0] exp_d, input logic exp_e,
                     input int hold);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sign = sign;
    sb.push_back({exp_e, exp_d});
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    e = sb.pop_front();
    chk({tag, ".rdata"}, rsp_rdata, e[31:0]);
    chk({tag, ".err"}, 32'(rsp_err), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD; req_size = 2'b10;
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, e[31:0]);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");
    txn("st_w10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 0);
    txn("ld_w10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    txn("st_z10",  1'b1, 32'h10, 32'h0,        2'b10, 1'b0, 32'h0,        1'b0, 0);
    txn("st_b13",  1'b1, 32'h13, 32'h55AA5580, 2'b00, 1'b0, 32'h0,        1'b0, 0);
    txn("ld_b13s", 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 0);
    txn("ld_b13u", 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0, 0);
    txn("ld_w10b", 1'b0, 32'h10, 32'h0,        2'b10, 1'b1, 32'h80000000, 1'b0, 0);
    txn("st_w10c", 1'b1, 32'h10, 32'h80017F00, 2'b10, 1'b0, 32'h0,        1'b0, 0);
    txn("ld_h12u", 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'h00008001, 1'b0, 0);
    txn("ld_h12s", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'hFFFF8001, 1'b0, 0);
    txn("ld_h10s", 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h00007F00, 1'b0, 0);
    txn("ld_b11s", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h0000007F, 1'b0, 0);
    txn("st_h12",  1'b1, 32'h12, 32'h9999ABCD, 2'b01, 1'b0, 32'h0,        1'b0, 0);
    txn("ld_hold", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hABCD7F00, 1'b0, 5);
    txn("ld_after_hold", 1'b0, 32'h10, 32'h0,  2'b10, 1'b0, 32'hABCD7F00, 1'b0, 0);
    txn("st_w20",  1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0, 0);
    txn("ld_w20",  1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("rst_wait");
    txn("ld_w20_old", 1'b0, 32'h20, 32'h0,     2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 0);
    txn("st_w00",  1'b1, 32'h0,    32'h11223344, 2'b10, 1'b0, 32'h0,      1'b0, 0);
`ifdef DMEM_RESP_ERR_EN
    txn("ld_w1002", 1'b0, 32'h1002, 32'h0,     2'b10, 1'b0, 32'h0,        1'b1, 0);
`else
    txn("ld_w1002", 1'b0, 32'h1002, 32'h0,     2'b10, 1'b0, 32'h11223344, 1'b0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
